// File: rtl/bus_txn_watchdog.sv
// Per-CPU bus transaction watchdog: per-beat timeout and early-drop abort detection,
// with round-robin serialisation of error reports and sticky per-CPU error flags.
//
// state  | meaning
// IDLE   | no transaction on this channel
// ACTIVE | block in progress, beat timer running
// DONE   | block completed, waiting for req to drop
// ERR    | timeout or abort raised, waiting for req to drop
module bus_txn_watchdog #(
    parameter int NUM_CPUS         = 2,
    parameter int BLOCK_SIZE_WORDS = 2,
    parameter int CNT_W            = 16,
    parameter int DEFAULT_TIMEOUT  = 25,
    localparam int SEL_W  = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
    localparam int BEAT_W = $clog2(BLOCK_SIZE_WORDS + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                enable,
    input  logic [CNT_W-1:0]    timeout_limit,
    input  logic [NUM_CPUS-1:0] req,
    input  logic [NUM_CPUS-1:0] beat_done,
    output logic [NUM_CPUS-1:0] busy,
    output logic                err_valid,
    input  logic                err_ready,
    output logic [SEL_W-1:0]    err_cpu,
    output logic                err_type,
    output logic [BEAT_W-1:0]   err_beats,
    output logic [NUM_CPUS-1:0] err_sticky,
    output logic [NUM_CPUS-1:0] err_overflow,
    input  logic [NUM_CPUS-1:0] clr_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_ERR} state_t;

    state_t              state     [NUM_CPUS];
    state_t              state_nxt [NUM_CPUS];
    logic [CNT_W-1:0]    cnt       [NUM_CPUS];
    logic [BEAT_W-1:0]   beats     [NUM_CPUS];
    logic [BEAT_W-1:0]   raise_beats [NUM_CPUS];
    logic [NUM_CPUS-1:0] raise;
    logic [NUM_CPUS-1:0] raise_type;

    logic [NUM_CPUS-1:0] pending;
    logic                pend_type  [NUM_CPUS];
    logic [BEAT_W-1:0]   pend_beats [NUM_CPUS];

    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    sel_rr;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel;
    logic                locked;
    logic                hs;
    logic [CNT_W-1:0]    lim;

    assign lim = (timeout_limit == '0) ? CNT_W'(DEFAULT_TIMEOUT) : timeout_limit;

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (RST) state[i] <= S_IDLE;
            else     state[i] <= state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            state_nxt[i] = state[i];
            if (!enable) begin
                state_nxt[i] = S_IDLE;
            end else begin
                case (state[i])
                    S_IDLE:   if (req[i]) state_nxt[i] = S_ACTIVE;
                    S_ACTIVE: begin
                        if (beat_done[i] && (beats[i] + BEAT_W'(1) == BEAT_W'(BLOCK_SIZE_WORDS)))
                            state_nxt[i] = S_DONE;
                        else if (!req[i])
                            state_nxt[i] = S_ERR;
                        else if (!beat_done[i] && cnt[i] == lim - CNT_W'(1))
                            state_nxt[i] = S_ERR;
                    end
                    default:  if (!req[i]) state_nxt[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            busy[i]        = (state[i] == S_ACTIVE);
            raise[i]       = (state[i] == S_ACTIVE) && (state_nxt[i] == S_ERR);
            raise_type[i]  = ~req[i];
            raise_beats[i] = beats[i] + BEAT_W'(beat_done[i]);
        end
    end

    // Counters idle at zero outside ACTIVE, so entering ACTIVE always starts clean.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (RST || !enable || state[i] != S_ACTIVE) begin
                cnt[i]   <= '0;
                beats[i] <= '0;
            end else if (beat_done[i]) begin
                cnt[i]   <= '0;
                beats[i] <= beats[i] + BEAT_W'(1);
            end else begin
                cnt[i]   <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        int  idx;
        logic found;
        sel_rr = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CPUS) idx = idx - NUM_CPUS;
            if (!found && pending[idx]) begin
                sel_rr = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign err_valid = |pending;
    assign sel       = locked ? sel_q : sel_rr;
    assign hs        = err_valid && err_ready;
    assign err_cpu   = err_valid ? sel : '0;
    assign err_type  = err_valid ? pend_type[sel] : 1'b0;
    assign err_beats = err_valid ? pend_beats[sel] : '0;

    // A stalled report freezes its selection until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr       <= '0;
            sel_q        <= '0;
            locked       <= 1'b0;
            pending      <= '0;
            err_sticky   <= '0;
            err_overflow <= '0;
            for (int i = 0; i < NUM_CPUS; i++) begin
                pend_type[i]  <= 1'b0;
                pend_beats[i] <= '0;
            end
        end else begin
            if (hs) begin
                locked <= 1'b0;
                rr_ptr <= (sel == SEL_W'(NUM_CPUS - 1)) ? '0 : sel + SEL_W'(1);
            end else if (err_valid) begin
                locked <= 1'b1;
                sel_q  <= sel;
            end
            for (int i = 0; i < NUM_CPUS; i++) begin
                if (raise[i]) begin
                    if (pending[i] && !(hs && sel == SEL_W'(i))) begin
                        err_overflow[i] <= 1'b1;
                    end else begin
                        pending[i]    <= 1'b1;
                        pend_type[i]  <= raise_type[i];
                        pend_beats[i] <= raise_beats[i];
                        err_overflow[i] <= err_overflow[i] & ~clr_err[i];
                    end
                end else begin
                    if (hs && sel == SEL_W'(i)) pending[i] <= 1'b0;
                    err_overflow[i] <= err_overflow[i] & ~clr_err[i];
                end
                err_sticky[i] <= raise[i] | (err_sticky[i] & ~clr_err[i]);
            end
        end
    end

endmodule
